// File: rtl/bit_count_pkg.sv
// Shared types and constants for the popcount engine scheduler.
package bit_count_pkg;

    localparam int DATA_W    = 8;
    localparam int SUM_W     = 4;
    localparam int N_REQ_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD,
        WAIT,
        RELEASE
    } state_t;

endpackage

// File: rtl/bit_count_sched_rr_arbiter.sv
// Round-robin winner search starting at ptr, with ptr advanced past the winner on grant.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic                     i_advance,
    output logic [$clog2(N_REQ)-1:0] o_winner,
    output logic                     o_any,
    output logic [$clog2(N_REQ)-1:0] o_ptr
);

    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] ptr;
    logic [PW:0]   idx;

    assign o_ptr = ptr;

    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
            if (!o_any && i_req[idx[PW-1:0]]) begin
                o_any    = 1'b1;
                o_winner = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (i_advance) begin
            ptr <= (o_winner == PW'(N_REQ-1)) ? '0 : o_winner + 1'b1;
        end
    end

endmodule

// File: rtl/bit_count_sched.sv
// Shares one popcount engine among N_REQ requesters and routes each result back.
// Handshake: o_gnt pulses once when an operand is taken; o_valid pulses once when its o_sum is ready.
module bit_count_sched
    import bit_count_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*DATA_W-1:0]  i_data,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [N_REQ-1:0]         o_valid,
    output logic [SUM_W-1:0]         o_sum,
    output logic                     o_busy,
    output logic                     o_eng_start,
    output logic                     o_eng_load,
    output logic [DATA_W-1:0]        o_eng_data,
    input  logic [SUM_W-1:0]         i_eng_sum,
    input  logic                     i_eng_done,
    output state_t                   o_state,
    output logic [$clog2(N_REQ)-1:0] o_ptr
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t        state;
    logic [PW-1:0] winner;
    logic [PW-1:0] win_q;
    logic          any;
    logic          advance;

    assign o_state = state;
    assign o_busy  = (state != IDLE);
    assign advance = (state == IDLE) && any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_advance (advance),
        .o_winner  (winner),
        .o_any     (any),
        .o_ptr     (o_ptr)
    );

    // Pulse outputs default low; each state raises the ones it owns for the next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            win_q       <= '0;
            o_gnt       <= '0;
            o_valid     <= '0;
            o_sum       <= '0;
            o_eng_start <= 1'b0;
            o_eng_load  <= 1'b0;
            o_eng_data  <= '0;
        end else begin
            o_gnt       <= '0;
            o_valid     <= '0;
            o_eng_start <= 1'b0;
            o_eng_load  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        win_q       <= winner;
                        o_eng_data  <= i_data[winner*DATA_W +: DATA_W];
                        o_gnt       <= ONE << winner;
                        o_eng_start <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    o_eng_load <= 1'b1;
                    state      <= LOAD;
                end
                LOAD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_eng_done) begin
                        o_sum       <= i_eng_sum;
                        o_valid     <= ONE << win_q;
                        o_eng_start <= 1'b1;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    o_eng_data <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
